// File: rtl/mp_pkg.sv
// rtl/mp_pkg.sv - shared sizes, mode constants and FSM states for the max-pool scheduler
package mp_pkg;

  localparam int DATA_W = 8;
  localparam int MAX_W  = 64;
  localparam int CNT_W  = 7;

  localparam logic MODE_BYP  = 1'b0;
  localparam logic MODE_POOL = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVEN,
    S_ODD,
    S_ISSUE,
    S_BYP,
    S_FIN
  } state_e;

endpackage

// File: rtl/mp_line_buf.sv
// rtl/mp_line_buf.sv - one-row line buffer, one write port and two combinational read ports
module mp_line_buf #(
  parameter int DATA_W = mp_pkg::DATA_W,
  parameter int MAX_W  = mp_pkg::MAX_W,
  parameter int AW     = $clog2(MAX_W)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  // Contents are never reset; a frame always rewrites a row before reading it.
  logic [DATA_W-1:0] mem_q [MAX_W];

  // Store the even-row pixel at its column.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/mp_scheduler.sv
// rtl/mp_scheduler.sv - raster pixel scheduler feeding a 2x2 max-pooling unit or bypassing it
module mp_scheduler #(
  parameter int DATA_W = mp_pkg::DATA_W,
  parameter int MAX_W  = mp_pkg::MAX_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     cfg_mode,
  input  logic [6:0]               cfg_w,
  input  logic [6:0]               cfg_h,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] mp_in,
  output logic                     mp_en,
  output logic                     mp_en_mp,
  output logic                     busy,
  output logic                     done
);
  import mp_pkg::*;

  localparam int AW = $clog2(MAX_W);

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [CNT_W-1:0]  w_q, w_d, h_q, h_d, row_q, row_d, col_q, col_d;
  logic [AW-1:0]     win_c_q, win_c_d;
  logic [1:0]        beat_q, beat_d;
  logic [DATA_W-1:0] bl_q, bl_d, br_q, br_d, byp_q, byp_d;
  logic              byp_en_q, byp_en_d;

  logic              hs, buf_we, col_last, row_last;
  logic [DATA_W-1:0] rd_a, rd_b;

  assign hs       = in_valid && in_ready;
  assign col_last = (col_q == w_q - 1'b1);
  assign row_last = (row_q == h_q - 1'b1);
  assign buf_we   = (state_q == S_EVEN) && hs;

  mp_line_buf #(.DATA_W(DATA_W), .MAX_W(MAX_W), .AW(AW)) u_line_buf (
    .clk     (clk),
    .we      (buf_we),
    .waddr   (col_q[AW-1:0]),
    .wdata   (in_data),
    .raddr_a (win_c_q - 1'b1),
    .raddr_b (win_c_q),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  // State and datapath registers; the line buffer is the only unreset storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      mode_q   <= MODE_BYP;
      w_q      <= '0;
      h_q      <= '0;
      row_q    <= '0;
      col_q    <= '0;
      win_c_q  <= '0;
      beat_q   <= '0;
      bl_q     <= '0;
      br_q     <= '0;
      byp_q    <= '0;
      byp_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      w_q      <= w_d;
      h_q      <= h_d;
      row_q    <= row_d;
      col_q    <= col_d;
      win_c_q  <= win_c_d;
      beat_q   <= beat_d;
      bl_q     <= bl_d;
      br_q     <= br_d;
      byp_q    <= byp_d;
      byp_en_q <= byp_en_d;
    end
  end

  // Next state plus counter/holding-register updates, advanced only on handshakes or issue beats.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    w_d      = w_q;
    h_d      = h_q;
    row_d    = row_q;
    col_d    = col_q;
    win_c_d  = win_c_q;
    beat_d   = beat_q;
    bl_d     = bl_q;
    br_d     = br_q;
    byp_d    = byp_q;
    byp_en_d = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        mode_d = cfg_mode;
        w_d    = cfg_w;
        h_d    = cfg_h;
        row_d  = '0;
        col_d  = '0;
        beat_d = '0;
        if (cfg_w == '0 || cfg_h == '0) state_d = S_FIN;
        else if (cfg_mode == MODE_POOL)  state_d = S_EVEN;
        else                             state_d = S_BYP;
      end
      S_BYP: if (hs) begin
        byp_en_d = 1'b1;
        byp_d    = in_data;
        if (col_last) begin
          col_d = '0;
          if (row_last) state_d = S_FIN;
          else          row_d   = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_EVEN: if (hs) begin
        if (col_last) begin
          col_d = '0;
          // A trailing unpaired row has just been swallowed here.
          if (row_last) state_d = S_FIN;
          else begin
            row_d   = row_q + 1'b1;
            state_d = S_ODD;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_ODD: if (hs) begin
        if (col_q[0]) begin
          br_d    = in_data;
          win_c_d = col_q[AW-1:0];
          col_d   = col_q + 1'b1;
          beat_d  = '0;
          state_d = S_ISSUE;
        end else begin
          // Even column: hold it; if it is the last column of an odd width it is dropped.
          bl_d = in_data;
          if (col_last) begin
            col_d = '0;
            if (row_last) state_d = S_FIN;
            else begin
              row_d   = row_q + 1'b1;
              state_d = S_EVEN;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_ISSUE: begin
        beat_d = beat_q + 1'b1;
        if (beat_q == 2'd3) begin
          // col_q already points past the window, so reaching w means the row is done.
          if (col_q == w_q) begin
            col_d = '0;
            if (row_last) state_d = S_FIN;
            else begin
              row_d   = row_q + 1'b1;
              state_d = S_EVEN;
            end
          end else begin
            state_d = S_ODD;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; mp_en_mp spans the whole pooling frame to keep the pooler aligned.
  always_comb begin
    in_ready = (state_q == S_EVEN) || (state_q == S_ODD) || (state_q == S_BYP);
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_FIN);
    mp_en_mp = (mode_q == MODE_POOL) &&
               ((state_q == S_EVEN) || (state_q == S_ODD) || (state_q == S_ISSUE));
    mp_en    = byp_en_q || (state_q == S_ISSUE);
    mp_in    = byp_q;
    if (state_q == S_ISSUE) begin
      case (beat_q)
        2'd0:    mp_in = rd_a;
        2'd1:    mp_in = rd_b;
        2'd2:    mp_in = bl_q;
        default: mp_in = br_q;
      endcase
    end
  end

endmodule

// File: doc/mp_scheduler.md
MP_SCHEDULER -- requirements
Module: mp_scheduler

Interface
REQ-001 The block SHALL have parameters: DATA_W, default 8, pixel width (signed); MAX_W, default 64, maximum frame width in pixels.
REQ-002 The block SHALL have ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset.
- start  input  1  one-cycle frame start request.
- cfg_mode  input  1  0 = bypass, 1 = 2x2 max pooling.
- cfg_w  input  7  frame width in pixels, 0..MAX_W.
- cfg_h  input  7  frame height in pixels.
- in_data  input  DATA_W  signed pixel, raster order.
- in_valid  input  1  in_data valid.
- in_ready  output  1  scheduler accepts a pixel.
- mp_in  output  DATA_W  pixel to the pooling unit.
- mp_en  output  1  pooling unit enable.
- mp_en_mp  output  1  pooling-mode select to the pooling unit.
- busy  output  1  frame in progress.
- done  output  1  one-cycle frame-complete pulse.

Function
REQ-003 States SHALL be IDLE, EVEN (even row, storing), ODD (odd row, pairing), ISSUE (4-beat window), BYP (bypass streaming), FIN.
REQ-004 In IDLE, start SHALL latch cfg_mode/cfg_w/cfg_h, clear row/col counters, and go to BYP (mode 0) or EVEN (mode 1); start while busy SHALL be ignored.
REQ-005 A pixel handshake SHALL occur when in_valid and in_ready are both high on a clock edge; in_ready SHALL be high only in EVEN, ODD and BYP.
REQ-006 BYP: each handshake SHALL drive mp_in = in_data and mp_en = 1 on the next cycle, with mp_en_mp = 0; throughput is one pixel per cycle.
REQ-007 EVEN: each accepted pixel SHALL be written to line buffer entry col; at the end of the row, go to ODD.
REQ-008 ODD: an even-column pixel SHALL be held in a bottom-left register; an odd-column handshake SHALL enter ISSUE on the next cycle.
REQ-009 ISSUE SHALL drive mp_en = 1 for exactly 4 consecutive cycles with mp_in = buf[c-1], buf[c], bottom-left, bottom-right (c = odd column), then return to ODD, or to EVEN/FIN at the end of the row.
REQ-010 mp_en_mp SHALL stay high continuously from entry to EVEN until FIN in pooling mode, so the pooling unit's 4-beat counter stays aligned with windows.
REQ-011 Odd cfg_w: the last column SHALL be accepted and dropped (no window); odd cfg_h: the last row SHALL be accepted and dropped.
REQ-012 Exactly floor(cfg_w/2)*floor(cfg_h/2) windows SHALL be issued per pooling frame, and cfg_w*cfg_h pixels accepted in either mode.
REQ-013 cfg_w = 0 or cfg_h = 0 SHALL go straight to FIN without accepting pixels.
REQ-014 FIN SHALL pulse done for one cycle, deassert busy and mp_en_mp, and go to IDLE; busy SHALL be high in every state except IDLE.
REQ-015 in_valid low SHALL stall counters without other effect; mp_en SHALL be low in every cycle not covered by REQ-006/REQ-009.

Reset
REQ-016 While reset is low: state = IDLE; in_ready, mp_en, mp_en_mp, busy and done = 0; mp_in = 0; counters = 0.
REQ-017 Reset mid-frame SHALL abort the frame without a done pulse; line buffer contents are not reset and SHALL not be relied on.

Structure
REQ-018 Package mp_pkg SHALL hold DATA_W, MAX_W, the state enumeration and the mode constants.
REQ-019 The line buffer (MAX_W x DATA_W, one write port, two combinational read ports) SHALL be the sub-module mp_line_buf.

Verification
REQ-020 Pool 4x2 frame, rows [1,5,-3,2] and [4,0,7,-8] -> two 4-beat groups (1,5,4,0) and (-3,2,7,-8); pooling unit outputs 5 then 7; one done pulse.
REQ-021 Bypass 3x1 frame [-128,0,127] -> mp_en for 3 cycles with the same values, mp_en_mp = 0, done after the third pixel.
REQ-022 Pool 5x3 frame -> 2 windows only; 15 pixels accepted; column 4 and row 2 dropped.
REQ-023 Pool 2x2 frame with in_valid toggling every cycle -> a single contiguous 4-beat group, in_ready low during ISSUE.
REQ-024 Reset asserted during ISSUE of the first window -> all outputs 0 immediately; no done pulse; a new start runs a clean frame.
REQ-025 cfg_w = 0, start -> done on the next FIN cycle, no handshakes; start during busy ignored.
